ram_cr: RTL

- Column-in / row-out 8x8 element transpose buffer. It is the write-by-column, read-by-row counterpart of the existing row-write / column-read transpose RAM.
- Accepts eight column words from an upstream stage on a valid/ready handshake, then streams eight row words downstream on a valid/ready handshake.
- Sits between the column-processing pass and the row-processing pass of the 2-D transform pipeline.
- Single clock domain.

---
 rtl/ram_cr.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/ram_cr.sv
// ram_cr: column-in / row-out 8x8 element transpose buffer.
//
// Eight column words are accepted on a valid/ready handshake and written into
// an 8x8 element store, then eight row words are streamed out on a second
// valid/ready handshake. Row words are always taken from a register (doo), so
// there is no combinational path from di to doo.
//
// Optional build macro: RAM_CR_PINGPONG_EN
//   undefined - single bank; fill and drain alternate (FILL/DRAIN FSM).
//   defined   - two banks; one bank fills while the other drains.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (also zeroes the store)
//   clr        in   synchronous abort of partial fill and pending drain
//   din_valid  in   column word present on di
//   din_ready  out  column accepted this cycle when din_valid is high
//   be         in   per-element write enable, active-low, be[7] gates MS lane
//   di         in   column word, row r element in lane 7-r
//   dout_valid out  row word present on doo
//   dout_ready in   downstream accepts the row word
//   doo        out  row word, column c element in lane 7-c
//   dout_last  out  high while doo carries row 7
module ram_cr #(
  parameter int BW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [7:0]      be,
  input  logic [8*BW-1:0] di,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [8*BW-1:0] doo,
  output logic            dout_last
);

`ifdef RAM_CR_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int CW = $clog2(NB*8);
  typedef logic [CW-1:0] col_t;

  // Store is indexed [bank*8 + column][row].
  logic [BW-1:0]   mem_q [NB*8][8];
  logic [2:0]      wc_q;
  logic [2:0]      rr_q;
  logic            din_ready_q;
  logic            dout_valid_q;
  logic            dout_last_q;
  logic [8*BW-1:0] doo_q;

  logic            wr_en;
  col_t            wr_col;
  col_t            rd_col0;
  logic [2:0]      rd_row;
  logic [8*BW-1:0] rd_word;

  assign wr_en      = din_valid & din_ready_q & ~clr;
  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign doo        = doo_q;

  // Column write: each element with its active-low enable clear takes its lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB*8; i++)
        for (int r = 0; r < 8; r++)
          mem_q[i][r] <= '0;
    end else if (wr_en) begin
      for (int r = 0; r < 8; r++)
        if (!be[7-r]) mem_q[wr_col][r] <= di[(7-r)*BW +: BW];
    end
  end

  // Row gather: column 0 goes to the MS lane.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < 8; c++)
      rd_word[(7-c)*BW +: BW] = mem_q[rd_col0 | col_t'(c)][rd_row];
  end

`ifdef RAM_CR_PINGPONG_EN
  logic       wb_q, wb_d;
  logic       rb_q, rb_d;
  logic       rd_bank;
  logic [1:0] full_q, full_d;
  logic [2:0] wc_d, rr_d;
  logic       din_ready_d, dout_valid_d, dout_last_d;
  logic [8*BW-1:0] doo_d;

  assign wr_col  = {wb_q, wc_q};
  assign rd_col0 = {rd_bank, 3'b000};

  // Next row to load: the following row of the current bank, or row 0 of the
  // next bank once the current bank's row 7 has left (or nothing is showing).
  always_comb begin
    rd_bank = rb_q;
    rd_row  = 3'd0;
    if (dout_valid_q && rr_q != 3'd7) rd_row = rr_q + 3'd1;
    else if (dout_valid_q)            rd_bank = ~rb_q;
  end

  // full_q[b] marks a bank holding rows not yet loaded onto doo. A bank can be
  // refilled as soon as its row 7 sits in doo, which keeps din_ready high
  // under full throughput.
  always_comb begin
    wc_d         = wc_q;
    wb_d         = wb_q;
    rb_d         = rb_q;
    rr_d         = rr_q;
    full_d       = full_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    doo_d        = doo_q;
    if (wr_en) begin
      wc_d = wc_q + 3'd1;
      if (wc_q == 3'd7) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end
    end
    if (dout_valid_q && rr_q != 3'd7) begin
      if (dout_ready) begin
        rr_d        = rd_row;
        doo_d       = rd_word;
        dout_last_d = (rd_row == 3'd7);
        if (rd_row == 3'd7) full_d[rb_q] = 1'b0;
      end
    end else if (!dout_valid_q || dout_ready) begin
      rb_d         = rd_bank;
      rr_d         = 3'd0;
      dout_last_d  = 1'b0;
      dout_valid_d = full_q[rd_bank];
      if (full_q[rd_bank]) doo_d = rd_word;
    end
    din_ready_d = ~full_d[wb_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      full_q       <= 2'b00;
      wc_q         <= 3'd0;
      rr_q         <= 3'd0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      doo_q        <= '0;
    end else if (clr) begin
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      full_q       <= 2'b00;
      wc_q         <= 3'd0;
      rr_q         <= 3'd0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      full_q       <= full_d;
      wc_q         <= wc_d;
      rr_q         <= rr_d;
      din_ready_q  <= din_ready_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      doo_q        <= doo_d;
    end
  end
`else
  typedef enum logic {FILL, DRAIN} state_e;
  state_e state_q;

  assign wr_col  = wc_q;
  assign rd_col0 = '0;
  // First DRAIN cycle loads row 0; afterwards each accepted row loads the next.
  assign rd_row  = dout_valid_q ? rr_q + 3'd1 : 3'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      wc_q         <= 3'd0;
      rr_q         <= 3'd0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      doo_q        <= '0;
    end else if (clr) begin
      state_q      <= FILL;
      wc_q         <= 3'd0;
      rr_q         <= 3'd0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (wr_en) begin
            wc_q <= wc_q + 3'd1;
            if (wc_q == 3'd7) begin
              state_q     <= DRAIN;
              din_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!dout_valid_q) begin
            doo_q        <= rd_word;
            dout_valid_q <= 1'b1;
            dout_last_q  <= 1'b0;
            rr_q         <= 3'd0;
          end else if (dout_ready) begin
            if (rr_q == 3'd7) begin
              state_q      <= FILL;
              dout_valid_q <= 1'b0;
              dout_last_q  <= 1'b0;
              rr_q         <= 3'd0;
              din_ready_q  <= 1'b1;
            end else begin
              rr_q        <= rd_row;
              doo_q       <= rd_word;
              dout_last_q <= (rr_q == 3'd6);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end
`endif

endmodule
